// File: rtl/axi_stb_pkg.sv
// Shared definitions for the burst-store write channel: response codes,
// responder FSM encoding and the beat geometry used by both ends of the link.
package axi_stb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } stb_state_e;

  localparam int STB_DATA_W     = 128;
  localparam int STB_BEAT_BYTES = STB_DATA_W / 8;

  // Number of low byte-address bits covered by one beat.
  function automatic int beat_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst address generator: latches the start word index and beat count on load,
// steps once per accepted beat and flags the final beat and out-of-buffer beats.
module axi_burst_addr_gen
  import axi_stb_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = STB_DATA_W,
  parameter int              LEN_W     = 16,
  parameter int              MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              step,
  output logic [IDX_W-1:0]  idx,
  output logic              last,
  output logic              out_of_range,
  output logic              misaligned
);

  localparam int OFF = beat_shift(DATA_W);

  logic [ADDR_W-1:0] rel;
  logic [ADDR_W-1:0] idx_d, idx_q;
  logic [LEN_W-1:0]  rem_d, rem_q;
  logic              mis_d, mis_q;

  // Byte offset from the buffer base; wraps modulo 2^ADDR_W before any range check.
  assign rel = start_addr - BASE_ADDR;

  // Next index/remaining-count: load on AW, advance one word per accepted beat.
  always_comb begin
    idx_d = idx_q;
    rem_d = rem_q;
    mis_d = mis_q;
    if (load) begin
      idx_d = rel >> OFF;
      rem_d = len;
      mis_d = |rel[OFF-1:0];
    end else if (step) begin
      idx_d = idx_q + ADDR_W'(1);
      rem_d = rem_q - LEN_W'(1);
    end
  end

  // Counter state; remaining counts down to zero so a full-length burst never overflows.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      rem_q <= '0;
      mis_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      rem_q <= rem_d;
      mis_q <= mis_d;
    end
  end

  assign idx          = idx_q[IDX_W-1:0];
  assign last         = (rem_q == '0);
  assign out_of_range = (idx_q >= ADDR_W'(MEM_DEPTH));
  assign misaligned   = mis_q;

endmodule

// File: rtl/axi_stb_resp.sv
// Write responder for the burst-store channel: takes one INCR burst at a time,
// writes each beat to the local buffer through a registered port and answers on B.
module axi_stb_resp
  import axi_stb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = STB_DATA_W,
  parameter int                LEN_W     = 16,
  parameter int                MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [ADDR_W-1:0]            s_awaddr,
  input  logic [LEN_W-1:0]             s_awlen,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  input  logic [DATA_W-1:0]            s_wdata,
  input  logic [DATA_W/8-1:0]          s_wstrb,
  input  logic                         s_wlast,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  output logic [1:0]                   s_bresp,
  output logic                         mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_wstrb
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_W / 8;

  stb_state_e        state_d, state_q;
  logic              awready_d, awready_q;
  logic              wready_d, wready_q;
  logic              bvalid_d, bvalid_q;
  logic [1:0]        bresp_d, bresp_q;
  logic              err_d, err_q;
  logic              we_d, we_q;
  logic [IDX_W-1:0]  maddr_d, maddr_q;
  logic [DATA_W-1:0] mdata_d, mdata_q;
  logic [STRB_W-1:0] mstrb_d, mstrb_q;

  logic             aw_hs, w_hs;
  logic [IDX_W-1:0] gen_idx;
  logic             gen_last, gen_oor, gen_mis;
  logic             beat_drop, beat_err;

  // Ready/valid are registered and mirror the state, so handshakes key off the state alone.
  assign aw_hs = (state_q == ST_IDLE) && s_awvalid;
  assign w_hs  = (state_q == ST_DATA) && s_wvalid;

  axi_burst_addr_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .LEN_W     (LEN_W),
    .MEM_DEPTH (MEM_DEPTH),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .load         (aw_hs),
    .start_addr   (s_awaddr),
    .len          (s_awlen),
    .step         (w_hs),
    .idx          (gen_idx),
    .last         (gen_last),
    .out_of_range (gen_oor),
    .misaligned   (gen_mis)
  );

  // A beat is dropped when outside the buffer or when the whole burst is misaligned;
  // a wlast that disagrees with the beat count only marks the burst as failed.
  assign beat_drop = gen_oor || gen_mis;
  assign beat_err  = beat_drop || (s_wlast != gen_last);

  // Next-state and next-output logic for the FSM and the buffer write port.
  always_comb begin
    state_d   = state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    err_d     = err_q;
    we_d      = 1'b0;
    maddr_d   = maddr_q;
    mdata_d   = mdata_q;
    mstrb_d   = mstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (s_awvalid) begin
          state_d   = ST_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
        end
      end
      ST_DATA: begin
        if (s_wvalid) begin
          err_d = err_q || beat_err;
          if (!beat_drop) begin
            we_d    = 1'b1;
            maddr_d = gen_idx;
            mdata_d = s_wdata;
            mstrb_d = s_wstrb;
          end
          if (gen_last) begin
            state_d  = ST_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      ST_RESP: begin
        if (s_bready) begin
          state_d   = ST_IDLE;
          awready_d = 1'b1;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          err_d     = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        bresp_d   = RESP_OKAY;
        err_d     = 1'b0;
      end
    endcase
  end

  // FSM state and all registered outputs; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
      mdata_q   <= '0;
      mstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      err_q     <= err_d;
      we_q      <= we_d;
      maddr_q   <= maddr_d;
      mdata_q   <= mdata_d;
      mstrb_q   <= mstrb_d;
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mdata_q;
  assign mem_wstrb = mstrb_q;

endmodule
